executor_merge: RTL and testbench
=================================

# executor_merge

Lock stage of the playfield executor. It takes a landed 4x4 piece and ORs it into matrix memory with one read-modify-write per piece row. It then launches the line-clear check stage through a one-cycle `check_v_o` pulse, waits for that stage's `check_done_i`, and reports completion. It sits between the piece-movement control and the line-clear check stage, and shares the matrix-memory port with that check stage.

## Interface
- `width_p`, 16: playfield columns (matrix word width).
- `height_p`, 32: playfield rows. Address 0 is the top row; `height_p-1` is the bottom row.
- `clk_i` input 1: clock.
- `reset_n_i` input 1: reset, asynchronous, active-low.
- `v_i` input 1: piece valid.
- `ready_o` output 1: block is idle and accepts a piece.
- `piece_i` input 16: piece bitmap. Row r = `piece_i[4r+3:4r]`; bit c of that nibble = column `x_i+c`.
- `x_i` input $clog2(width_p): column of piece bit 0.
- `y_i` input $clog2(height_p): matrix row of piece row 0. Piece row r maps to address `y_i+r`.
- `mm_read_addr_o` output $clog2(height_p): matrix read address. Read data is combinational.
- `mm_read_data_i` input width_p: matrix read data.
- `mm_write_addr_o` output $clog2(height_p): matrix write address.
- `mm_write_data_o` output width_p: matrix write data.
- `mm_write_v_o` output 1: matrix write enable, sampled at the clock edge.
- `check_v_o` output 1: one-cycle start pulse to the line-clear check stage.
- `check_done_i` input 1: line-clear check stage finished.
- `done_o` output 1: one-cycle pulse, lock and check complete.
- `collide_o` output 1: a piece cell landed on an occupied cell during the current or last lock.
- `clip_o` output 1: a piece cell fell outside the playfield during the current or last lock.
- `top_out_o` output 1: a piece cell was written into row 0 during the current or last lock.

## Operation
- **States:** eIDLE, eMerge, eKick, eWait, eDone. Reset enters eIDLE.
- **eIDLE:**
  - `ready_o`=1.
  - On `v_i`: capture `piece_i`, `x_i`, `y_i`; clear row counter r, `collide_o`, `clip_o`, `top_out_o`; go to eMerge.
- **eMerge:** one cycle per r = 0..3.
  - Read and write address = captured y + r, computed at $clog2(height_p)+1 bits.
  - Row mask = zero-extended nibble r shifted left by x, computed at width_p+4 bits.
  - `mm_write_data_o` = `mm_read_data_i` | mask[width_p-1:0].
  - `mm_write_v_o`=1 only when the nibble is nonzero and y+r < height_p.
  - If y+r ≥ height_p: drive address 0, no write. If the nibble is nonzero, set `clip_o`.
  - If mask[width_p+3:width_p] != 0, set `clip_o`. The in-range bits are still written.
  - If (`mm_read_data_i` & mask) != 0 on a write cycle, set `collide_o`. The OR is still written.
  - If a write occurs at address 0, set `top_out_o`.
  - After r=3, go to eKick.
- **eKick:** `check_v_o`=1 for exactly one cycle; go to eWait.
- **eWait:** all memory outputs idle. On `check_done_i`, go to eDone.
- **eDone:** `done_o`=1 for one cycle; go to eIDLE.
- **Memory port ownership:** outside eMerge, `mm_write_v_o`=0 and both addresses = 0. The check stage owns the memory port in eWait.
- **Status flags:** `collide_o`, `clip_o`, `top_out_o` are sticky from their set point until the next accept, and remain readable after `done_o`.

## Timing
- **Reset values:** every output is 0 except `ready_o`=1. Captured registers are 0.
- **Reset mid-operation:** on `reset_n_i` low, the FSM goes to eIDLE immediately. Writes and pulses stop with no further memory writes.
- **Sequence:** accept at edge T. Then:
  - eMerge at cycles T+1..T+4.
  - `check_v_o` at T+5.
  - `check_done_i` observed earliest at T+6.
  - `done_o` one cycle after `check_done_i` is sampled.
  - `ready_o` the cycle after `done_o`.
- **Minimum lock latency:** 7 cycles, accept to `done_o`.
- `check_done_i` is ignored outside eWait.
- `v_i` is ignored when `ready_o`=0; no pending request is held.

## Test plan
- **Clean lock:** empty memory, `piece_i`=16'h0033 (O piece), x=4, y=30. Required:
  - rows 30 and 31 become 16'h0030;
  - no writes for r=2,3;
  - `check_v_o` at T+5;
  - all flags 0.
- **Collision:** row 10 preloaded with 16'h0010; T piece 16'h0072, x=3, y=9. Required:
  - row 10 = 16'h0038;
  - `collide_o`=1.
- **Clip:**
  - Right edge: I piece 16'h000F, x=14. Required: row = 16'hC000, `clip_o`=1.
  - Bottom edge: y=31 with a nonzero piece row 1. Required: no write to the wrapped address, `clip_o`=1.
- **Top-out:** piece 16'h0001, x=0, y=0. Required: row 0 bit 0 set, `top_out_o`=1.
- **Handshake:** `check_done_i` held 0 for 20 cycles. Required:
  - FSM stays in eWait;
  - `v_i` pulses ignored;
  - `done_o` exactly one cycle after `check_done_i`=1;
  - early `check_done_i` pulses during eMerge have no effect.
- **Async reset:** assert `reset_n_i` during the r=2 cycle, with no clock edge. Required:
  - `mm_write_v_o` drops immediately;
  - `ready_o`=1;
  - memory rows for r≥2 unchanged.

Source files
------------

// File: rtl/executor_merge.sv
// Lock stage of the playfield executor: ORs a landed 4x4 piece into matrix
// memory one row per cycle, then hands off to the line-clear check stage.
module executor_merge #(
   parameter int width_p  = 16,
   parameter int height_p = 32
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        v_i,
   output logic                        ready_o,
   input  logic [15:0]                 piece_i,
   input  logic [$clog2(width_p)-1:0]  x_i,
   input  logic [$clog2(height_p)-1:0] y_i,
   output logic [$clog2(height_p)-1:0] mm_read_addr_o,
   input  logic [width_p-1:0]          mm_read_data_i,
   output logic [$clog2(height_p)-1:0] mm_write_addr_o,
   output logic [width_p-1:0]          mm_write_data_o,
   output logic                        mm_write_v_o,
   output logic                        check_v_o,
   input  logic                        check_done_i,
   output logic                        done_o,
   output logic                        collide_o,
   output logic                        clip_o,
   output logic                        top_out_o
);

   localparam int XW = $clog2(width_p);
   localparam int AW = $clog2(height_p);
   localparam logic [AW:0] HEIGHT = (AW+1)'(height_p);

   typedef enum logic [2:0] {eIDLE, eMerge, eKick, eWait, eDone} state_e;

   state_e            state_q, state_d;
   logic [15:0]       piece_q, piece_d;
   logic [XW-1:0]     x_q, x_d;
   logic [AW-1:0]     y_q, y_d;
   logic [1:0]        r_q, r_d;
   logic              collide_q, collide_d;
   logic              clip_q, clip_d;
   logic              top_out_q, top_out_d;

   logic [AW:0]          row_sum;
   logic                 in_range;
   logic [3:0]           nibble;
   logic [width_p+3:0]   mask;
   logic [AW-1:0]        row_addr;
   logic                 row_wr;

   // Row arithmetic carries one extra bit so y+r past the bottom is detected, not wrapped
   always_comb begin
      row_sum  = {1'b0, y_q} + (AW+1)'(r_q);
      in_range = row_sum < HEIGHT;
      nibble   = 4'(piece_q >> {r_q, 2'b00});
      mask     = {{width_p{1'b0}}, nibble} << x_q;
      row_addr = in_range ? row_sum[AW-1:0] : '0;
      row_wr   = in_range && (nibble != '0);
   end

   // State register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= eIDLE;
      else            state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         eIDLE:   if (v_i) state_d = eMerge;
         eMerge:  if (r_q == 2'd3) state_d = eKick;
         eKick:   state_d = eWait;
         eWait:   if (check_done_i) state_d = eDone;
         eDone:   state_d = eIDLE;
         default: state_d = eIDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ready_o         = 1'b0;
      check_v_o       = 1'b0;
      done_o          = 1'b0;
      mm_read_addr_o  = '0;
      mm_write_addr_o = '0;
      mm_write_data_o = '0;
      mm_write_v_o    = 1'b0;
      case (state_q)
         eIDLE:  ready_o = 1'b1;
         eMerge: begin
            mm_read_addr_o  = row_addr;
            mm_write_addr_o = row_addr;
            mm_write_data_o = mm_read_data_i | mask[width_p-1:0];
            mm_write_v_o    = row_wr;
         end
         eKick:  check_v_o = 1'b1;
         eDone:  done_o = 1'b1;
         default: ;
      endcase
      collide_o = collide_q;
      clip_o    = clip_q;
      top_out_o = top_out_q;
   end

   // Capture and sticky status flags
   always_comb begin
      piece_d   = piece_q;
      x_d       = x_q;
      y_d       = y_q;
      r_d       = r_q;
      collide_d = collide_q;
      clip_d    = clip_q;
      top_out_d = top_out_q;
      case (state_q)
         eIDLE: begin
            if (v_i) begin
               piece_d   = piece_i;
               x_d       = x_i;
               y_d       = y_i;
               r_d       = '0;
               collide_d = 1'b0;
               clip_d    = 1'b0;
               top_out_d = 1'b0;
            end
         end
         eMerge: begin
            r_d = r_q + 2'd1;
            if ((!in_range && nibble != '0) || mask[width_p+3:width_p] != '0)
               clip_d = 1'b1;
            if (row_wr && (mm_read_data_i & mask[width_p-1:0]) != '0)
               collide_d = 1'b1;
            if (row_wr && row_addr == '0)
               top_out_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         piece_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         r_q       <= '0;
         collide_q <= 1'b0;
         clip_q    <= 1'b0;
         top_out_q <= 1'b0;
      end else begin
         piece_q   <= piece_d;
         x_q       <= x_d;
         y_q       <= y_d;
         r_q       <= r_d;
         collide_q <= collide_d;
         clip_q    <= clip_d;
         top_out_q <= top_out_d;
      end
   end

endmodule

// File: tb/tb_executor_merge.sv
// Self-checking bench for executor_merge: cell-level playfield model plus
// directed corner cases and randomized locks.
module tb_executor_merge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        v_i = 1'b0;
   logic        ready_o;
   logic [15:0] piece_i = '0;
   logic [3:0]  x_i = '0;
   logic [4:0]  y_i = '0;
   logic [4:0]  mm_read_addr;
   logic [15:0] mm_read_data;
   logic [4:0]  mm_write_addr;
   logic [15:0] mm_write_data;
   logic        mm_write_v;
   logic        check_v_o;
   logic        check_done_i = 1'b0;
   logic        done_o;
   logic        collide_o;
   logic        clip_o;
   logic        top_out_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] mem [32];
   logic [15:0] ref_mem [32];
   logic        poke_v = 1'b0;
   logic [4:0]  poke_addr = '0;
   logic [15:0] poke_data = '0;

   always #5 clk = ~clk;

   executor_merge #(.width_p(16), .height_p(32)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .ready_o(ready_o),
      .piece_i(piece_i), .x_i(x_i), .y_i(y_i),
      .mm_read_addr_o(mm_read_addr), .mm_read_data_i(mm_read_data),
      .mm_write_addr_o(mm_write_addr), .mm_write_data_o(mm_write_data),
      .mm_write_v_o(mm_write_v), .check_v_o(check_v_o),
      .check_done_i(check_done_i), .done_o(done_o),
      .collide_o(collide_o), .clip_o(clip_o), .top_out_o(top_out_o)
   );

   assign mm_read_data = mem[mm_read_addr];

   always @(posedge clk) begin
      if (poke_v) mem[poke_addr] <= poke_data;
      else if (mm_write_v) mem[mm_write_addr] <= mm_write_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input int a, input logic [15:0] d);
      poke_v = 1'b1; poke_addr = 5'(a); poke_data = d;
      @(negedge clk);
      poke_v = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) poke(i, 16'h0000);
   endtask

   task automatic cmp_mem(input string tag);
      for (int i = 0; i < 32; i++) check_eq($sformatf("%s_row%0d", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
   endtask

   // Cell-by-cell placement of the piece onto the reference playfield
   task automatic model(input logic [15:0] p, input int x, input int y,
                        output bit c, output bit cl, output bit t);
      c = 0; cl = 0; t = 0;
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++)
            if (p[4*r+cc]) begin
               int row = y + r;
               int col = x + cc;
               if (row >= 32 || col >= 16) cl = 1;
               else begin
                  if (ref_mem[row][col]) c = 1;
                  ref_mem[row][col] = 1'b1;
                  if (row == 0) t = 1;
               end
            end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50 && !ready_o; i++) @(negedge clk);
      check_eq("ready_before_accept", 32'(ready_o), 32'd1);
   endtask

   task automatic lock(input string tag, input logic [15:0] p, input int x, input int y, input int dly);
      bit ec, ecl, et;
      int kick_at, done_req, done_at;
      model(p, x, y, ec, ecl, et);
      wait_ready();
      v_i = 1'b1; piece_i = p; x_i = 4'(x); y_i = 5'(y);
      @(negedge clk);
      kick_at = -1; done_req = -1; done_at = -1;
      for (int cyc = 1; cyc < 200; cyc++) begin
         if (done_o) begin
            done_at = cyc;
            v_i = 1'b0; check_done_i = 1'b0;
            break;
         end
         if (check_v_o && kick_at < 0) kick_at = cyc;
         v_i = 1'($urandom_range(0, 1));
         piece_i = 16'($urandom);
         x_i = 4'($urandom);
         y_i = 5'($urandom);
         if (cyc < 5) check_done_i = 1'($urandom_range(0, 1));
         else if (kick_at >= 0 && cyc == kick_at + 1 + dly) begin
            check_done_i = 1'b1; done_req = cyc;
         end else check_done_i = 1'b0;
         @(negedge clk);
      end
      check_eq({tag, "_kick_cycle"}, 32'(kick_at), 32'd5);
      check_eq({tag, "_done_seen"}, 32'(done_at >= 0), 32'd1);
      check_eq({tag, "_done_cycle"}, 32'(done_at), 32'(done_req + 1));
      check_eq({tag, "_collide"}, 32'(collide_o), 32'(ec));
      check_eq({tag, "_clip"}, 32'(clip_o), 32'(ecl));
      check_eq({tag, "_top_out"}, 32'(top_out_o), 32'(et));
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
      check_eq({tag, "_ready_after"}, 32'(ready_o), 32'd1);
      check_eq({tag, "_flags_hold"}, {29'd0, collide_o, clip_o, top_out_o}, {29'd0, ec, ecl, et});
      cmp_mem(tag);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      @(negedge clk); @(negedge clk);
      check_eq("rst_outputs", {22'd0, ready_o, check_v_o, done_o, mm_write_v, collide_o, clip_o, top_out_o, 3'd0},
               {22'd0, 1'b1, 6'd0, 3'd0});
      check_eq("rst_addrs", {22'd0, mm_read_addr, mm_write_addr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Clean lock: O piece at the bottom
      lock("clean", 16'h0033, 4, 30, 0);
      check_eq("clean_row30", 32'(mem[30]), 32'h0030);
      check_eq("clean_row31", 32'(mem[31]), 32'h0030);

      // Collision with a preloaded cell
      poke(10, 16'h0010);
      lock("collide", 16'h0072, 3, 9, 1);
      check_eq("collide_row10", 32'(mem[10]), 32'h0038);
      check_eq("collide_flag", 32'(collide_o), 32'd1);

      // Right-edge clip
      clear_mem();
      lock("clip_right", 16'h000F, 14, 12, 2);
      check_eq("clip_right_row", 32'(mem[12]), 32'hC000);
      check_eq("clip_right_flag", 32'(clip_o), 32'd1);

      // Bottom-edge clip: piece row 1 falls past row 31, row 0 must stay empty
      lock("clip_bottom", 16'h0011, 0, 31, 0);
      check_eq("clip_bottom_row0", 32'(mem[0]), 32'h0000);
      check_eq("clip_bottom_flag", 32'(clip_o), 32'd1);

      // Top-out
      lock("top_out", 16'h0001, 0, 0, 0);
      check_eq("top_out_row0", 32'(mem[0]), 32'h0001);
      check_eq("top_out_flag", 32'(top_out_o), 32'd1);

      // Long check-stage handshake
      lock("handshake", 16'h0660, 6, 15, 20);

      // Asynchronous reset during the r=2 merge cycle
      begin
         bit c, cl, t;
         wait_ready();
         model(16'h00FF, 2, 20, c, cl, t);
         v_i = 1'b1; piece_i = 16'hFFFF; x_i = 4'd2; y_i = 5'd20;
         @(negedge clk);
         v_i = 1'b0;
         @(negedge clk);
         @(negedge clk);
         check_eq("arst_pre_write_v", 32'(mm_write_v), 32'd1);
         #1 rst_n = 1'b0;
         #1;
         check_eq("arst_write_v", 32'(mm_write_v), 32'd0);
         check_eq("arst_ready", 32'(ready_o), 32'd1);
         check_eq("arst_flags", {29'd0, collide_o, clip_o, top_out_o}, 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         check_eq("arst_idle", {30'd0, ready_o, check_v_o}, 32'd2);
         cmp_mem("arst");
      end

      // Randomized locks against the playfield model
      for (int n = 0; n < 25; n++) begin
         if (n % 8 == 0) clear_mem();
         lock($sformatf("rand%0d", n), 16'($urandom), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 4)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
